sd_adc: RTL and testbench

SD_ADC -- requirements
Module: sd_adc

---
 rtl/sd_adc.sv | 88 ++++++++
 tb/tb_sd_adc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sd_adc.sv
// First-order sigma-delta ADC back end: comparator feedback flop, windowed ones
// counter decimator, and a 2^LPF_DEPTH-tap moving-average filter.
`timescale 1ns/1ps
module sd_adc #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 10,
    parameter int LPF_DEPTH = 3
) (
    input  logic             clk,
    input  logic             ares,
    input  logic             cmp,
    output logic             sdm,
    output logic [WIDTH-1:0] q,
    output logic             wr
);

    localparam int NTAP = 1 << LPF_DEPTH;
    localparam int SW   = WIDTH + LPF_DEPTH;
    localparam logic [ACC_WIDTH:0] RAW_MAX = (ACC_WIDTH+1)'((1 << WIDTH) - 1);

    // Assert asynchronously, release on a clock edge so every flop leaves reset together.
    logic rst_n;
    always_ff @(posedge clk or negedge ares) begin
        if (!ares) rst_n <= 1'b0;
        else       rst_n <= 1'b1;
    end

    logic [ACC_WIDTH-1:0] win;
    logic [ACC_WIDTH:0]   ones;
    logic [WIDTH-1:0]     raw;
    logic                 stb;
    logic [WIDTH-1:0]     hist [NTAP];
    logic [SW-1:0]        sum;

    logic                 terminal;
    logic [ACC_WIDTH:0]   count_final;
    logic [ACC_WIDTH:0]   count_shift;
    logic [WIDTH-1:0]     raw_next;
    logic [SW-1:0]        sum_upd;

    always_comb begin
        terminal    = &win;
        count_final = ones + {{ACC_WIDTH{1'b0}}, sdm};
        count_shift = count_final >> (ACC_WIDTH - WIDTH);
        // Only a window of all ones overflows WIDTH bits after the shift.
        raw_next    = (count_shift > RAW_MAX) ? RAW_MAX[WIDTH-1:0] : count_shift[WIDTH-1:0];
        sum_upd     = sum + SW'(raw) - SW'(hist[NTAP-1]);
    end

    // The sdm flop is the sampling point for the asynchronous comparator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdm  <= 1'b0;
            win  <= '0;
            ones <= '0;
            raw  <= '0;
            stb  <= 1'b0;
        end else begin
            sdm <= cmp;
            win <= win + 1'b1;
            stb <= terminal;
            if (terminal) begin
                raw  <= raw_next;
                ones <= '0;
            end else begin
                ones <= count_final;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) hist[i] <= '0;
            sum <= '0;
            q   <= '0;
            wr  <= 1'b0;
        end else begin
            wr <= stb;
            if (stb) begin
                hist[0] <= raw;
                for (int i = 1; i < NTAP; i++) hist[i] <= hist[i-1];
                sum <= sum_upd;
                q   <= WIDTH'(sum_upd >> LPF_DEPTH);
            end
        end
    end

endmodule

// File: tb/tb_sd_adc.sv
// Directed bench for sd_adc: table of expected q per wr strobe for fixed
// comparator patterns, plus reset and closed-loop sequences.
`timescale 1ns/1ps
module tb_sd_adc;

    logic       clk = 1'b0;
    logic       ares;
    logic       cmp = 1'b0;
    logic       sdm;
    logic [7:0] q;
    logic       wr;

    always #5 clk = ~clk;

    sd_adc dut (
        .clk  (clk),
        .ares (ares),
        .cmp  (cmp),
        .sdm  (sdm),
        .q    (q),
        .wr   (wr)
    );

    int   cyc = 0;
    logic cmp_prev = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        cmp_prev <= cmp;
    end

    int n_vec = 0;
    int n_bad = 0;
    int mode = 0;
    int target = 0;
    int err = 0;
    int rel_cyc = 0;
    int prev_wr = -1;

    typedef struct {
        int mode;
        int exp_q;
    } vec_t;
    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Comparator model. Mode 2 puts cmp=1 on the second edge after release so
    // every window sees 512 ones; mode 3 is a first-order loop on the error
    // between target and the fed-back DAC level (0 or 256).
    initial begin
        forever begin
            @(negedge clk);
            case (mode)
                0: cmp = 1'b0;
                1: cmp = 1'b1;
                2: cmp = (((cyc - rel_cyc) % 2) == 1);
                default: begin
                    err = err + target - (sdm ? 256 : 0);
                    cmp = (err > 0);
                end
            endcase
        end
    end

    task automatic do_reset(input int new_mode, input int pre_wait);
        repeat (pre_wait) @(negedge clk);
        mode = new_mode;
        err  = 0;
        @(negedge clk);
        #2;
        ares = 1'b0;
        #1;
        check("rst_async_sdm", sdm, 0);
        check("rst_async_q", q, 0);
        check("rst_async_wr", wr, 0);
        repeat (3) @(negedge clk);
        check("rst_hold_q", q, 0);
        check("rst_hold_wr", wr, 0);
        ares    = 1'b1;
        rel_cyc = cyc;
        prev_wr = -1;
    endtask

    task automatic wait_wr(output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 1100) begin
            @(negedge clk);
            if (wr === 1'b1) begin
                at = cyc;
                break;
            end
            n++;
        end
        if (at < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL wr_timeout: got no wr in 1100 cycles, expected one");
        end
    endtask

    // Waits for the next strobe and checks its timing; q is left for the caller.
    task automatic next_wr(output int at);
        wait_wr(at);
        if (at >= 0) begin
            if (prev_wr < 0) check("first_wr_delay", at - (rel_cyc + 1), 1025);
            else             check("wr_period", at - prev_wr, 1024);
            check("sdm_latency", sdm, cmp_prev);
            prev_wr = at;
        end
    endtask

    initial begin
        int at;
        int cur_mode;
        int targets [3];

        vecs = '{
            '{0, 0}, '{0, 0}, '{0, 0},
            '{1, 31}, '{1, 63}, '{1, 95}, '{1, 127}, '{1, 159},
            '{1, 191}, '{1, 223}, '{1, 255}, '{1, 255}, '{1, 255},
            '{2, 16}, '{2, 32}, '{2, 48}, '{2, 64}, '{2, 80},
            '{2, 96}, '{2, 112}, '{2, 128}, '{2, 128}
        };
        targets = '{5, 200, 77};

        ares     = 1'b0;
        cur_mode = -1;
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].mode != cur_mode) begin
                do_reset(vecs[i].mode, (cur_mode < 0) ? 2 : 300);
                cur_mode = vecs[i].mode;
            end
            next_wr(at);
            if (at >= 0) begin
                check("q", q, vecs[i].exp_q);
                @(negedge clk);
                check("wr_width", wr, 0);
            end
        end

        do_reset(3, 300);
        for (int t = 0; t < 3; t++) begin
            target = targets[t];
            for (int k = 0; k < 9; k++) begin
                next_wr(at);
                if (at >= 0) begin
                    @(negedge clk);
                    check("loop_wr_width", wr, 0);
                end
            end
            n_vec++;
            if ((int'(q) < target - 2) || (int'(q) > target + 2)) begin
                n_bad++;
                $display("FAIL loop_q: got %0d, expected %0d +/-2", q, target);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no end of test by 1500000 ns, expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
